clk_tick_monitor: RTL
=====================

# clk_tick_monitor

Receive-side companion to the game's divided-clock generator: samples a slow, free-running square wave (nominally toggling every 51 `clk` cycles) in the fast `clk` domain. It turns each edge into a one-cycle tick pulse for the game timers. It also measures the half-period and reports lock, loss-of-clock and out-of-tolerance events so control logic can trust or reject the tick stream.

## Interface
- HALF_PERIOD, 51, expected `clk` cycles between consecutive edges of `clk_in`
- TOL, 2, allowed absolute deviation of a measured half-period from HALF_PERIOD
- LOCK_CNT, 4, consecutive in-tolerance half-periods required to declare lock (1..15)
- TIMEOUT, 200, `clk` cycles without an edge before declaring loss (must be > HALF_PERIOD+TOL, < 255)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- clk_in  in  1  slow square wave, asynchronous to `clk`
- tick_rise  out  1  one-cycle pulse per accepted rising edge of `clk_in`
- tick_fall  out  1  one-cycle pulse per accepted falling edge of `clk_in`
- half_len  out  8  last measured edge-to-edge interval in `clk` cycles
- locked  out  1  high in LOCKED state
- lost  out  1  high in LOST state
- err_cnt  out  8  count of out-of-tolerance intervals while LOCKED, saturating at 255

## Operation
- Two-flop synchronizer `clk_in`→s0→s1, then level register `lvl`; edge = s1 ≠ lvl. rise = s1&~lvl, fall = ~s1&lvl.
- Interval counter `cnt` (8 bit): cleared to 0 on an edge cycle, else increments, saturating at 255.
- On edge: half_len ← cnt+1 (saturating at 255); tick_rise/tick_fall registered from rise/fall.
- In-tolerance test: |cnt+1 − HALF_PERIOD| ≤ TOL, computed in 9-bit signed arithmetic.
- FSM, 2-bit state, 4-bit match counter `mc`:
  - IDLE: no edge since reset. Edge → ACQ, mc=0 (first interval unanchored, not judged). cnt reaches TIMEOUT → LOST.
  - ACQ: edge in tolerance → mc+1; mc+1 = LOCK_CNT → LOCKED. Edge out of tolerance → mc=0, stay. Timeout → LOST.
  - LOCKED: edge in tolerance → stay. Out of tolerance → ACQ, mc=0, err_cnt+1 (saturating). Timeout → LOST.
  - LOST: next edge → ACQ, mc=0, that interval not judged (cnt saturated).
- Edge and timeout in same cycle: edge wins; timeout ignored.
- Ticks are emitted in every state, including LOST and IDLE.

## Timing
- Reset values: tick_rise=0, tick_fall=0, half_len=0, locked=0, lost=0, err_cnt=0; s0,s1,lvl=0; cnt=0; state IDLE.
- clk_in level change setting up before posedge k: s0 at k, s1 at k+1, edge detected in cycle after k+1, tick/half_len/state/locked/lost update at posedge k+2 → visible 3 cycles after k, high exactly one cycle.
- locked/lost are registered state decodes, updated on the same edge as the tick causing the transition.
- Timeout: lost rises at the posedge where cnt transitions to TIMEOUT (TIMEOUT+1 cycles after last edge).
- rst mid-operation: all outputs to reset values immediately; an edge on the first sample after release is not detected unless s1 becomes 1 (lvl resets to 0).
- Steady 51/51 input: tick pulse every 51 cycles, alternating rise/fall, half_len=51.

## Configuration
- CLK_TICK_DEGLITCH_EN defined: a 2-bit stability counter on s1; `lvl` updates only after s1 differs from lvl for 3 consecutive cycles. Tick latency becomes 5 cycles; pulses/glitches shorter than 3 cycles produce no tick and do not reset `cnt`. Measured half_len unchanged for clean inputs.
- Undefined: no filter, latency 3 cycles, every synchronized level change is an edge.

## Test plan
- Reset then clk_in 51/51 square wave → first tick 3 cycles after first transition; locked rises at the 5th edge (1 unjudged + 4 matches); half_len=51; err_cnt=0.
- Locked, one half-period stretched to 55 → half_len=55, locked drops same cycle, err_cnt=1; relocks after 4 further good intervals.
- Locked, intervals of 49 and 53 → remain LOCKED, err_cnt=0 (within TOL=2).
- Stop clk_in high → lost=1, locked=0 at 201 cycles after last edge; resume → tick on next edge, lost=0, ACQ, relock after 4 more good intervals.
- Assert rst while LOCKED with err_cnt=3 → all outputs 0 at once; after release, IDLE and reacquires normally.
- With CLK_TICK_DEGLITCH_EN: inject 2-cycle high glitch mid low phase → no tick, half_len still 51; clean edge tick latency 5 cycles. Without macro: same glitch → two ticks and out-of-tolerance intervals.

Source files
------------

// File: rtl/clk_tick_monitor_if.sv
// Bus between the slow-clock source and its tick monitor: the sampled wave in,
// tick pulses and lock/health status out.
interface clk_tick_monitor_if;
    logic       i_clk_in;
    logic       o_tick_rise;
    logic       o_tick_fall;
    logic [7:0] o_half_len;
    logic       o_locked;
    logic       o_lost;
    logic [7:0] o_err_cnt;

    modport master (
        output i_clk_in,
        input  o_tick_rise, o_tick_fall, o_half_len, o_locked, o_lost, o_err_cnt
    );

    modport slave (
        input  i_clk_in,
        output o_tick_rise, o_tick_fall, o_half_len, o_locked, o_lost, o_err_cnt
    );
endinterface

// File: rtl/clk_tick_monitor.sv
// Turns edges of a slow asynchronous square wave into tick pulses and tracks its
// half-period lock. Define CLK_TICK_DEGLITCH_EN to filter pulses shorter than 3 cycles.
module clk_tick_monitor #(
    parameter int HALF_PERIOD = 51,
    parameter int TOL         = 2,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 200
) (
    input  logic               clk,
    input  logic               rst,
    clk_tick_monitor_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED, S_LOST} state_t;

    logic        r_s0, r_s1, r_lvl;
    logic [7:0]  r_cnt;
    state_t      r_state, w_state_n;
    logic [3:0]  r_mc, w_mc_n;
    logic        w_err_inc;
    logic        w_edge, w_rise, w_fall, w_ok, w_to;
    logic [7:0]  w_len;
    logic signed [8:0] w_diff;
    logic [8:0]  w_abs;
    logic        r_tick_rise, r_tick_fall, r_locked, r_lost;
    logic [7:0]  r_half_len, r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else begin
            r_s0 <= bus.i_clk_in;
            r_s1 <= r_s0;
        end
    end

`ifdef CLK_TICK_DEGLITCH_EN
    // Accept a level change only on its third consecutive mismatching cycle.
    logic [1:0] r_dg;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dg <= 2'd0;
        else if (w_edge || (r_s1 == r_lvl))
            r_dg <= 2'd0;
        else
            r_dg <= r_dg + 2'd1;
    end
    assign w_edge = (r_s1 != r_lvl) && (r_dg == 2'd2);
`else
    assign w_edge = (r_s1 != r_lvl);
`endif

    assign w_rise = w_edge & r_s1;
    assign w_fall = w_edge & ~r_s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_lvl <= 1'b0;
        else if (w_edge)
            r_lvl <= r_s1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= 8'd0;
        else if (w_edge)
            r_cnt <= 8'd0;
        else if (r_cnt != 8'hFF)
            r_cnt <= r_cnt + 8'd1;
    end

    // Interval length uses the saturated value so the signed difference cannot wrap.
    assign w_len  = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
    assign w_diff = $signed({1'b0, w_len}) - $signed(9'(HALF_PERIOD));
    assign w_abs  = w_diff[8] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_ok   = (w_abs <= 9'(TOL));
    assign w_to   = !w_edge && (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mc    <= 4'd0;
        end else begin
            r_state <= w_state_n;
            r_mc    <= w_mc_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_mc_n    = r_mc;
        w_err_inc = 1'b0;
        unique case (r_state)
            S_IDLE, S_LOST: begin
                if (w_edge) begin
                    w_state_n = S_ACQ;
                    w_mc_n    = 4'd0;
                end else if (w_to && (r_state == S_IDLE)) begin
                    w_state_n = S_LOST;
                end
            end
            S_ACQ: begin
                if (w_edge) begin
                    if (!w_ok) begin
                        w_mc_n = 4'd0;
                    end else if ((r_mc + 4'd1) == 4'(LOCK_CNT)) begin
                        w_state_n = S_LOCKED;
                        w_mc_n    = 4'd0;
                    end else begin
                        w_mc_n = r_mc + 4'd1;
                    end
                end else if (w_to) begin
                    w_state_n = S_LOST;
                end
            end
            S_LOCKED: begin
                if (w_edge) begin
                    if (!w_ok) begin
                        w_state_n = S_ACQ;
                        w_mc_n    = 4'd0;
                        w_err_inc = 1'b1;
                    end
                end else if (w_to) begin
                    w_state_n = S_LOST;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_rise <= 1'b0;
            r_tick_fall <= 1'b0;
            r_half_len  <= 8'd0;
            r_locked    <= 1'b0;
            r_lost      <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_tick_rise <= w_rise;
            r_tick_fall <= w_fall;
            if (w_edge)
                r_half_len <= w_len;
            r_locked <= (w_state_n == S_LOCKED);
            r_lost   <= (w_state_n == S_LOST);
            if (w_err_inc && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.o_tick_rise = r_tick_rise;
    assign bus.o_tick_fall = r_tick_fall;
    assign bus.o_half_len  = r_half_len;
    assign bus.o_locked    = r_locked;
    assign bus.o_lost      = r_lost;
    assign bus.o_err_cnt   = r_err_cnt;
endmodule
